// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch unit for a simple non-pipelined core. The unit issues one
// instruction-memory read and waits for the ack. It then holds the returned
// word for the decoder until the instruction retires. On retirement it loads
// the next PC and fetches again.
//
// States:
//   FETCH - irom_req high, waiting for irom_ack
//   HOLD  - inst_valid high, waiting for exec_done
//   HALT  - misaligned-target fault; no requests; left only by reset
//
// Optional feature (compile-time macro IF_MISALIGN_CHK_EN):
//   defined   - a next PC with npc[1:0] != 00 is loaded into pc, the unit
//               enters HALT and misalign is raised.
//   undefined - npc[1:0] is forced to 00 before loading pc, HALT is never
//               entered, and misalign is tied low.
//
// Parameters:
//   RESET_PC   - byte address of the first instruction fetched after reset
//
// Ports:
//   cpu_clk    in   1   clock; all state changes on its rising edge
//   cpu_rst    in   1   synchronous active-high reset
//   npc_op     in   2   next-PC select: 00 pc+4, 01 jalr, 10 pc+imm, 11 pc+4
//   imm        in  32   sign-extended immediate of the held instruction
//   rs1_data   in  32   rs1 read data of the held instruction
//   exec_done  in   1   held instruction retires this cycle
//   irom_req   out  1   instruction-memory read request
//   irom_addr  out 32   request byte address (equals pc)
//   irom_ack   in   1   irom_rdata valid this cycle
//   irom_rdata in  32   instruction word from memory
//   inst       out 32   held instruction
//   inst_valid out  1   inst is valid and stable
//   pc         out 32   address of the held or in-flight instruction
//   pc4        out 32   pc + 4 (combinational, for link writeback)
//   misalign   out  1   misaligned-target fault flag
// ---------------------------------------------------------------------------
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic [1:0]  npc_op,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        exec_done,
   output logic        irom_req,
   output logic [31:0] irom_addr,
   input  logic        irom_ack,
   input  logic [31:0] irom_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        misalign
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] w_pc4;
   logic [31:0] w_npc_raw;
   logic [31:0] w_npc_load;
   logic        w_capture;
   logic        w_load_pc;

   // ------------------------------------------------------------------------
   // Next-PC arithmetic. All sums wrap modulo 2^32.
   // ------------------------------------------------------------------------
   assign w_pc4 = r_pc + 32'd4;

   always_comb begin
      // NOTE: every signal written in a combinational block gets a default
      // first, so no path can leave it unassigned and infer a latch.
      w_npc_raw = w_pc4;
      case (npc_op)
         2'b01:   w_npc_raw = (rs1_data + imm) & ~32'd1;  // jalr clears bit 0
         2'b10:   w_npc_raw = r_pc + imm;
         default: w_npc_raw = w_pc4;                      // 00 and 11
      endcase
   end

`ifdef IF_MISALIGN_CHK_EN
   // The raw target is loaded as-is so that pc shows the faulting address.
   assign w_npc_load = w_npc_raw;
`else
   // No fault path: the target is silently word-aligned.
   assign w_npc_load = w_npc_raw & 32'hFFFF_FFFC;
`endif

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge cpu_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (cpu_rst) r_state <= ST_FETCH;
      else         r_state <= w_next_state;
   end

   // ------------------------------------------------------------------------
   // FSM: next state and datapath strobes. The state gates both handshakes,
   // so an ack outside FETCH or an exec_done outside HOLD has no effect.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_load_pc    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (irom_ack) begin
               w_capture    = 1'b1;
               w_next_state = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (exec_done) begin
               w_load_pc    = 1'b1;
               w_next_state = ST_FETCH;
`ifdef IF_MISALIGN_CHK_EN
               if (w_npc_raw[1:0] != 2'b00) w_next_state = ST_HALT;
`endif
            end
         end
         ST_HALT: begin
            w_next_state = ST_HALT;
         end
         default: begin
            w_next_state = ST_FETCH;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers. Reset wins over a same-cycle exec_done or ack, so
   // the instruction in flight is abandoned.
   // ------------------------------------------------------------------------
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         r_pc   <= RESET_PC;
         r_inst <= NOP_INST;
      end else begin
         if (w_load_pc) r_pc   <= w_npc_load;
         if (w_capture) r_inst <= irom_rdata;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. The request is masked while reset is asserted, so the first
   // request appears in the first cycle after reset is released.
   // ------------------------------------------------------------------------
   assign irom_req   = (r_state == ST_FETCH) && !cpu_rst;
   assign irom_addr  = r_pc;
   assign inst       = r_inst;
   assign inst_valid = (r_state == ST_HOLD);
   assign pc         = r_pc;
   assign pc4        = w_pc4;

`ifdef IF_MISALIGN_CHK_EN
   assign misalign = (r_state == ST_HALT);
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed bench for ifetch_unit. A behavioural model tracks the architectural
// view of the unit on every cycle: the current PC, whether an instruction
// word is held, the held word, and the halt condition. The model is updated
// from the spec rules on each rising edge. A compare process checks all DUT
// outputs against the model on each falling edge. Hand-computed literal
// checks pin the model at the documented scenarios.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        cpu_clk;
   logic        cpu_rst;
   logic [1:0]  npc_op;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        exec_done;
   logic        irom_req;
   logic [31:0] irom_addr;
   logic        irom_ack;
   logic [31:0] irom_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        misalign;

   int n_vec = 0;
   int n_err = 0;

   ifetch_unit #(.RESET_PC(RESET_PC)) dut (
      .cpu_clk    (cpu_clk),
      .cpu_rst    (cpu_rst),
      .npc_op     (npc_op),
      .imm        (imm),
      .rs1_data   (rs1_data),
      .exec_done  (exec_done),
      .irom_req   (irom_req),
      .irom_addr  (irom_addr),
      .irom_ack   (irom_ack),
      .irom_rdata (irom_rdata),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc),
      .pc4        (pc4),
      .misalign   (misalign)
   );

   initial begin
      cpu_clk = 1'b0;
      forever #5 cpu_clk = ~cpu_clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: PC plus an "instruction held" flag.
   // ------------------------------------------------------------------------
   logic [31:0] m_pc     = RESET_PC;
   logic [31:0] m_inst   = NOP;
   logic        m_held   = 1'b0;
   logic        m_halted = 1'b0;
   logic        checking = 1'b0;

   function automatic logic [31:0] target(input logic [31:0] cur, input logic [1:0] op,
                                           input logic [31:0] im, input logic [31:0] rs1);
      logic [31:0] t;
      if (op == 2'b01)      t = (rs1 + im) & ~32'd1;
      else if (op == 2'b10) t = cur + im;
      else                  t = cur + 32'd4;
      return t;
   endfunction

   always @(posedge cpu_clk) begin
      logic [31:0] t;
      if (cpu_rst) begin
         m_pc = RESET_PC; m_inst = NOP; m_held = 1'b0; m_halted = 1'b0;
      end else if (m_halted) begin
         // parked until reset
      end else if (!m_held) begin
         if (irom_ack) begin
            m_inst = irom_rdata;
            m_held = 1'b1;
         end
      end else if (exec_done) begin
         t = target(m_pc, npc_op, imm, rs1_data);
         m_held = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
         m_pc = t;
         if (t % 4 != 0) m_halted = 1'b1;
`else
         m_pc = t - (t % 4);
`endif
      end
   end

   always @(negedge cpu_clk) begin
      if (checking) begin
         check("model.irom_req", {31'd0, irom_req}, {31'd0, !cpu_rst && !m_held && !m_halted});
         check("model.irom_addr", irom_addr, m_pc);
         check("model.pc", pc, m_pc);
         check("model.pc4", pc4, m_pc + 32'd4);
         check("model.inst_valid", {31'd0, inst_valid}, {31'd0, m_held});
         check("model.misalign", {31'd0, misalign}, {31'd0, m_halted});
         if (m_held) check("model.inst", inst, m_inst);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge.
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge cpu_clk);
      #1;
   endtask

   // Wait (bounded) for a request, keep it waiting for 'waits' cycles, then ack.
   task automatic serve(input int waits, input logic [31:0] word, input logic [31:0] exp_addr);
      int budget = 16;
      while (!irom_req && budget > 0) begin
         step();
         budget--;
      end
      check("serve.req_seen", {31'd0, irom_req}, 32'd1);
      for (int i = 0; i < waits; i++) begin
         check("serve.wait_addr", irom_addr, exp_addr);
         step();
         check("serve.wait_req", {31'd0, irom_req}, 32'd1);
      end
      check("serve.ack_addr", irom_addr, exp_addr);
      irom_ack = 1'b1; irom_rdata = word;
      step();
      irom_ack = 1'b0; irom_rdata = $urandom;
      check("serve.valid", {31'd0, inst_valid}, 32'd1);
      check("serve.inst", inst, word);
   endtask

   task automatic retire(input logic [1:0] op, input logic [31:0] im, input logic [31:0] rs1);
      npc_op = op; imm = im; rs1_data = rs1; exec_done = 1'b1;
      step();
      exec_done = 1'b0; npc_op = 2'b00; imm = $urandom; rs1_data = $urandom;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cpu_rst = 1'b1; npc_op = 2'b00; imm = 32'd0; rs1_data = 32'd0;
      exec_done = 1'b0; irom_ack = 1'b0; irom_rdata = 32'd0;

      // Reset state.
      step();
      checking = 1'b1;
      step();
      check("rst.req", {31'd0, irom_req}, 32'd0);
      check("rst.pc", pc, 32'h0000_0000);
      check("rst.pc4", pc4, 32'h0000_0004);
      check("rst.inst", inst, 32'h0000_0013);
      check("rst.valid", {31'd0, inst_valid}, 32'd0);

      // First request with zero-wait ack.
      cpu_rst = 1'b0;
      #1;
      check("c0.req", {31'd0, irom_req}, 32'd1);
      check("c0.addr", irom_addr, 32'h0000_0000);
      serve(0, 32'h0010_0093, 32'h0);

      // ack while holding is ignored.
      irom_ack = 1'b1; irom_rdata = 32'hDEAD_BEEF;
      step();
      irom_ack = 1'b0;
      check("hold.inst_kept", inst, 32'h0010_0093);

      // Sequential, then a three-cycle ack delay; exec_done while fetching is ignored.
      retire(2'b00, 32'h0, 32'h0);
      check("seq.addr", irom_addr, 32'h0000_0004);
      exec_done = 1'b1;
      serve(2, 32'h1111_1111, 32'h4);
      exec_done = 1'b0;
      check("seq.pc_kept", pc, 32'h0000_0004);

      retire(2'b11, 32'h0, 32'h0);
      check("op11.addr", irom_addr, 32'h0000_0008);
      serve(1, 32'h2222_2222, 32'h8);
      retire(2'b00, 32'h0, 32'h0);
      serve(0, 32'h3333_3333, 32'hC);
      retire(2'b00, 32'h0, 32'h0);
      serve(0, 32'h4444_4444, 32'h10);

      // Branch backwards, then jalr with bit 0 cleared.
      retire(2'b10, 32'hFFFF_FFF8, 32'h0);
      check("br.addr", irom_addr, 32'h0000_0008);
      serve(0, 32'h5555_5555, 32'h8);
      retire(2'b01, 32'h0000_0004, 32'h0000_0101);
      check("jalr.addr", irom_addr, 32'h0000_0104);
      serve(0, 32'h6666_6666, 32'h104);

      // Wrap-around at the top of the address space.
      retire(2'b01, 32'h0000_0004, 32'hFFFF_FFF8);
      check("top.addr", irom_addr, 32'hFFFF_FFFC);
      check("top.pc4", pc4, 32'h0000_0000);
      serve(0, 32'h7777_7777, 32'hFFFF_FFFC);
      retire(2'b00, 32'h0, 32'h0);
      check("wrap.addr", irom_addr, 32'h0000_0000);

      // exec_done and ack together in HOLD: only the retirement counts.
      serve(0, 32'h8888_8888, 32'h0);
      irom_ack = 1'b1; irom_rdata = 32'h9999_9999;
      retire(2'b00, 32'h0, 32'h0);
      irom_ack = 1'b0;
      check("both.valid", {31'd0, inst_valid}, 32'd0);
      check("both.addr", irom_addr, 32'h0000_0004);

      // Misaligned branch target from pc=0.
      serve(0, 32'hAAAA_AAAA, 32'h4);
      retire(2'b10, 32'hFFFF_FFFC, 32'h0);
      serve(0, 32'hBBBB_BBBB, 32'h0);
      retire(2'b10, 32'h0000_0006, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
      check("mis.flag", {31'd0, misalign}, 32'd1);
      check("mis.pc", pc, 32'h0000_0006);
      for (int i = 0; i < 20; i++) begin
         check("mis.req_low", {31'd0, irom_req}, 32'd0);
         step();
      end
      cpu_rst = 1'b1;
      step();
      cpu_rst = 1'b0;
      #1;
      check("mis.flag_cleared", {31'd0, misalign}, 32'd0);
      serve(0, 32'hCCCC_CCCC, 32'h0);
`else
      check("mis.addr", irom_addr, 32'h0000_0004);
      check("mis.flag", {31'd0, misalign}, 32'd0);
      serve(0, 32'hCCCC_CCCC, 32'h4);
      retire(2'b00, 32'h0, 32'h0);
      serve(0, 32'hCCCC_CCCD, 32'h8);
`endif

      // Reset together with exec_done in HOLD: reset wins.
      cpu_rst = 1'b1;
      retire(2'b10, 32'h0000_0100, 32'h0);
      check("rsthold.pc", pc, 32'h0000_0000);
      check("rsthold.valid", {31'd0, inst_valid}, 32'd0);
      check("rsthold.inst", inst, 32'h0000_0013);
      check("rsthold.req", {31'd0, irom_req}, 32'd0);
      cpu_rst = 1'b0;
      #1;
      check("rsthold.req_after", {31'd0, irom_req}, 32'd1);
      serve(0, 32'h0010_0093, 32'h0);
      step();

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 cpu_clk  input  1  single clock; all state updates on rising edge.
REQ-003 cpu_rst  input  1  reset, synchronous, active-high.
REQ-004 npc_op  input  2  next-PC select: 00 pc+4, 01 jalr (rs1_data+imm), 10 pc+imm, 11 treated as 00.
REQ-005 imm  input  32  sign-extended immediate of the held instruction.
REQ-006 rs1_data  input  32  rs1 read data of the held instruction.
REQ-007 exec_done  input  1  held instruction retires this cycle; PC advances.
REQ-008 irom_req  output  1  instruction-memory read request.
REQ-009 irom_addr  output  32  byte address of the request; equals pc.
REQ-010 irom_ack  input  1  irom_rdata valid this cycle.
REQ-011 irom_rdata  input  32  instruction word from memory.
REQ-012 inst  output  32  held instruction to the decoder/control unit.
REQ-013 inst_valid  output  1  inst is valid and stable.
REQ-014 pc  output  32  address of the held/in-flight instruction.
REQ-015 pc4  output  32  pc+4, combinational, for link writeback.
REQ-016 misalign  output  1  misaligned-target fault flag (see Configuration).

Function
REQ-017 FSM states: FETCH (irom_req=1, waiting for ack), HOLD (inst_valid=1, waiting for exec_done), HALT (fault, no requests).
REQ-018 FETCH: irom_req shall be 1; on the edge where irom_ack=1, inst shall capture irom_rdata and state shall move to HOLD.
REQ-019 Latency: ack in the first FETCH cycle N gives inst_valid=1 in cycle N+1; each extra wait cycle adds one cycle.
REQ-020 HOLD: irom_req=0; inst and pc shall stay constant until exec_done=1.
REQ-021 On the edge where state=HOLD and exec_done=1: pc<=npc, inst_valid<=0, state<=FETCH, giving exactly one bubble cycle before the next request.
REQ-022 npc shall be combinational from pc, npc_op, imm, rs1_data; jalr target = (rs1_data+imm) with bit 0 cleared.
REQ-023 All address arithmetic shall be 32-bit modulo: pc=32'hFFFF_FFFC with npc_op=00 gives npc=32'h0000_0000.
REQ-024 irom_ack outside FETCH and exec_done outside HOLD shall be ignored; if both are high in one cycle, only the one that matches the current state shall take effect.
REQ-025 pc4 shall track pc combinationally in every state, including reset.

Reset
REQ-026 With cpu_rst=1 at an edge: pc<=RESET_PC, state<=FETCH, inst<=32'h0000_0013 (nop), inst_valid<=0, misalign<=0; irom_req shall be 0 while cpu_rst=1.
REQ-027 Reset during FETCH or HOLD shall abandon the current instruction. The memory is reset on the same signal, so an ack from before the reset is never returned.
REQ-028 The first request shall be issued in the first cycle with cpu_rst=0, with irom_addr=RESET_PC.

Configuration
REQ-029 Macro IF_MISALIGN_CHK_EN defined: if npc[1:0]!=00 at the exec_done edge, pc shall load npc, state shall go to HALT, misalign shall be 1, irom_req shall be 0 and inst_valid shall be 0. HALT shall be left only by reset.
REQ-030 Macro IF_MISALIGN_CHK_EN undefined: npc[1:0] shall be forced to 00 before loading pc; HALT shall be unreachable; misalign shall be tied to 0.

Verification
REQ-031 Reset release, RESET_PC=0, zero-wait ack with rdata=32'h0010_0093 -> cycle 0 req=1 addr=0, cycle 1 inst_valid=1 inst=32'h0010_0093.
REQ-032 Three-cycle ack delay -> irom_req high for 3 cycles, addr held at 0, inst_valid rises one cycle after the ack.
REQ-033 pc=0x10, npc_op=10, imm=32'hFFFF_FFF8, exec_done=1 -> next irom_addr=0x08. Then npc_op=01, rs1_data=0x101, imm=0x4 -> next irom_addr=0x104.
REQ-034 pc=32'hFFFF_FFFC, npc_op=00, exec_done -> irom_addr=0; pc4 at pc=0xFFFFFFFC reads 0.
REQ-035 Reset asserted in a HOLD cycle together with exec_done=1 -> next cycle pc=RESET_PC, inst_valid=0, inst=nop, no pc update to npc.
REQ-036 Build with IF_MISALIGN_CHK_EN, npc_op=10, pc=0, imm=0x6 -> misalign=1, pc=0x6, irom_req stays 0 for 20 cycles. Build without it -> next irom_addr=0x4.
